// File: rtl/jtframe_cen_pll.sv
// jtframe_cen_pll: CH fractional clock enables at clk*num/den with toggle outputs and a lock flag
module jtframe_cen_pll #(
    parameter int CH       = 4,
    parameter int CW       = 16,
    parameter int LOCK_CYC = 30,
    parameter int LCW      = 8,
    localparam int CHW     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_num,
    input  logic [CW-1:0]  cfg_den,
    input  logic           align,
    output logic [CH-1:0]  cen,
    output logic [CH-1:0]  tgl,
    output logic           locked
);
    logic [CW-1:0]  num_q[CH], num_d[CH], den_q[CH], den_d[CH], acc_q[CH], acc_d[CH];
    logic [CW:0]    sum[CH];
    logic [CH-1:0]  cen_q, cen_d, tgl_q, tgl_d, hit, go, fire;
    logic [LCW-1:0] lcnt_q, lcnt_d;
    logic           locked_q, locked_d, wr_ok, run;

    assign wr_ok = cfg_we && (32'(cfg_ch) < 32'(CH));
    // a valid write stalls every channel in the same cycle it lands
    assign run   = locked_q && !wr_ok;

    always_comb begin
        lcnt_d   = wr_ok ? '0 : locked_q ? lcnt_q : lcnt_q + 1'b1;
        locked_d = !wr_ok && (locked_q || lcnt_q == LCW'(LOCK_CYC - 1));
        for (int i = 0; i < CH; i++) begin
            hit[i]   = wr_ok && cfg_ch == CHW'(i);
            num_d[i] = hit[i] ? cfg_num : num_q[i];
            den_d[i] = hit[i] ? cfg_den : den_q[i];
            sum[i]   = {1'b0, acc_q[i]} + {1'b0, num_q[i]};
            go[i]    = run && !align && |num_q[i] && |den_q[i];
            fire[i]  = go[i] && sum[i] >= {1'b0, den_q[i]};
            // saturated ratios reset the phase so acc never reaches den
            acc_d[i] = !go[i] ? '0 : !fire[i] ? sum[i][CW-1:0] :
                       num_q[i] >= den_q[i] ? '0 : CW'(sum[i] - {1'b0, den_q[i]});
            cen_d[i] = fire[i];
            tgl_d[i] = (align || hit[i]) ? 1'b0 : tgl_q[i] ^ fire[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                num_q[i] <= '0;
                den_q[i] <= CW'(1);
                acc_q[i] <= '0;
            end
            cen_q    <= '0;
            tgl_q    <= '0;
            lcnt_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            num_q    <= num_d;
            den_q    <= den_d;
            acc_q    <= acc_d;
            cen_q    <= cen_d;
            tgl_q    <= tgl_d;
            lcnt_q   <= lcnt_d;
            locked_q <= locked_d;
        end
    end

    assign cen    = cen_q;
    assign tgl    = tgl_q;
    assign locked = locked_q;
endmodule

// File: tb/tb_jtframe_cen_pll.sv
// tb_jtframe_cen_pll: directed vectors and multi-cycle sequences for jtframe_cen_pll
module tb_jtframe_cen_pll;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cfg_we = 1'b0, align = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_num = '0, cfg_den = '0;
    logic [3:0]  cen, tgl;
    logic        locked;
    logic        cfg_we3 = 1'b0;
    logic [1:0]  cfg_ch3 = '0;
    logic [15:0] cfg_num3 = '0, cfg_den3 = '0;
    logic [2:0]  cen3, tgl3;
    logic        locked3;
    int total = 0, bad = 0;

    jtframe_cen_pll u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_num(cfg_num), .cfg_den(cfg_den), .align(align),
        .cen(cen), .tgl(tgl), .locked(locked)
    );

    jtframe_cen_pll #(.CH(3), .LOCK_CYC(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3),
        .cfg_num(cfg_num3), .cfg_den(cfg_den3), .align(1'b0),
        .cen(cen3), .tgl(tgl3), .locked(locked3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       al;
        logic [3:0] ecen;
        logic [3:0] etgl;
        logic       elk;
    } vec_t;
    vec_t tbl[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [15:0] n, input logic [15:0] d);
        cfg_we = 1'b1; cfg_ch = ch; cfg_num = n; cfg_den = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_lock(input string name, input int exp);
        int n = 0;
        while (!locked && n < 200) begin
            tick();
            n++;
        end
        chk(name, n, exp);
    endtask

    task automatic wait_lock3(input string name, input int exp);
        int n = 0;
        while (!locked3 && n < 50) begin
            tick();
            n++;
        end
        chk(name, n, exp);
    endtask

    initial begin
        int c0, c1, c2, c3, last, gaps_bad, nolock, first0, stray;
        tbl[0]  = '{1'b0, 4'b1100, 4'b1100, 1'b1};
        tbl[1]  = '{1'b0, 4'b1101, 4'b0001, 1'b1};
        tbl[2]  = '{1'b0, 4'b1110, 4'b1111, 1'b1};
        tbl[3]  = '{1'b0, 4'b1101, 4'b0010, 1'b1};
        tbl[4]  = '{1'b0, 4'b1100, 4'b1110, 1'b1};
        tbl[5]  = '{1'b0, 4'b1111, 4'b0001, 1'b1};
        tbl[6]  = '{1'b0, 4'b1100, 4'b1101, 1'b1};
        tbl[7]  = '{1'b0, 4'b1111, 4'b0010, 1'b1};
        tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 1'b1};
        tbl[9]  = '{1'b0, 4'b1100, 4'b1100, 1'b1};
        tbl[10] = '{1'b0, 4'b1101, 4'b0001, 1'b1};

        tick();
        tick();
        chk("reset_cen", cen, 4'b0);
        chk("reset_tgl", tgl, 4'b0);
        chk("reset_locked", locked, 1'b0);
        rst_n = 1'b1;
        for (int i = 1; i < 30; i++) tick();
        chk("unlocked_edge29", locked, 1'b0);
        tick();
        chk("locked_edge30", locked, 1'b1);
        chk("disabled_cen", cen, 4'b0);

        wr(2'd0, 16'd1, 16'd2);
        chk("unlock_on_write", locked, 1'b0);
        wr(2'd1, 16'd3, 16'd8);
        wr(2'd2, 16'd5, 16'd5);
        wr(2'd3, 16'd9, 16'd4);
        wait_lock("relock_cfg", 30);
        chk("cen_at_lock", cen, 4'b0);

        foreach (tbl[k]) begin
            align = tbl[k].al;
            tick();
            align = 1'b0;
            chk($sformatf("vec%0d_cen", k), cen, tbl[k].ecen);
            chk($sformatf("vec%0d_tgl", k), tgl, tbl[k].etgl);
            chk($sformatf("vec%0d_locked", k), locked, tbl[k].elk);
        end

        c0 = 0; c1 = 0; c2 = 0; c3 = 0; last = -1; gaps_bad = 0; nolock = 0;
        for (int t = 0; t < 800; t++) begin
            tick();
            if (!locked) nolock++;
            if (cen[0]) c0++;
            if (cen[2]) c2++;
            if (cen[3]) c3++;
            if (cen[1]) begin
                if (last >= 0 && !((t - last) inside {2, 3})) gaps_bad++;
                last = t;
                c1++;
            end
        end
        chk("ch1_count_800", c1, 300);
        chk("ch1_gaps", gaps_bad, 0);
        chk("ch0_count_800", c0, 400);
        chk("ch2_sat_count", c2, 800);
        chk("ch3_sat_count", c3, 800);
        chk("stayed_locked", nolock, 0);

        wr(2'd3, 16'd9, 16'd0);
        chk("unlock_ch3_den0", locked, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        wr(2'd0, 16'd1, 16'd4);
        stray = 0;
        for (int i = 1; i < 30; i++) begin
            tick();
            if (cen != 4'b0 || locked) stray++;
        end
        chk("paused_while_unlocked", stray, 0);
        tick();
        chk("relock_restart", locked, 1'b1);
        chk("cen_at_relock", cen, 4'b0);
        c0 = 0; c1 = 0; c2 = 0; c3 = 0; first0 = -1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (cen[0]) begin
                c0++;
                if (first0 < 0) first0 = t;
            end
            if (cen[1]) c1++;
            if (cen[2]) c2++;
            if (cen[3]) c3++;
        end
        chk("ch0_first_pulse", first0, 4);
        chk("ch0_quarter_count", c0, 10);
        chk("ch1_old_ratio", c1, 15);
        chk("ch2_old_ratio", c2, 40);
        chk("ch3_den0_silent", c3, 0);

        for (int i = 0; i < $urandom_range(1, 5); i++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cen", cen, 4'b0);
        chk("async_rst_tgl", tgl, 4'b0);
        chk("async_rst_locked", locked, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_lock("relock_after_reset", 30);
        tick();
        tick();
        chk("cfg_cleared_by_reset", cen, 4'b0);

        chk("d3_locked", locked3, 1'b1);
        cfg_we3 = 1'b1; cfg_ch3 = 2'd0; cfg_num3 = 16'd1; cfg_den3 = 16'd1;
        tick();
        cfg_we3 = 1'b0;
        chk("d3_unlock", locked3, 1'b0);
        wait_lock3("d3_relock", 4);
        tick();
        chk("d3_cen_full", cen3, 3'b001);
        cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_num3 = 16'd0; cfg_den3 = 16'd0;
        tick();
        cfg_we3 = 1'b0;
        chk("d3_bad_ch_locked", locked3, 1'b1);
        chk("d3_bad_ch_cen", cen3, 3'b001);
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cen3 != 3'b001 || !locked3) stray++;
        end
        chk("d3_bad_ch_nochange", stray, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
